sevenseg_scan: RTL and testbench

- Parametrised multiplexed N-digit hex seven-segment driver with PWM brightness, per-digit decimal points and tear-free value update.
- Sits between the system register file / debug bus and board anode/segment pins; drives displays without series resistors.
- Successor to the fixed 4-digit driver. Adds:
  - digit-count and polarity parameters
  - runtime brightness
  - load/ack shadow-register handshake committed on frame boundaries
  - anti-ghost dead cycle

---
 rtl/sevenseg_scan.sv | 156 +++++++++++++++
 tb/tb_sevenseg_scan.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed N-digit hex seven-segment driver with PWM
// brightness, per-digit decimal points and frame-synchronous value update.
// Optional leading-zero blanking: define SEVENSEG_SCAN_LZB_EN.
module sevenseg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE_BITS  = 10,
    parameter int DUTY_BITS      = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic                    load_ack,
    input  logic [DUTY_BITS-1:0]    brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic                    frame_start
);

    localparam int   DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);

    logic [PRESCALE_BITS-1:0] pre;
    logic [DUTY_BITS-1:0]     phase;
    logic [DIG_W-1:0]         digit;
    logic                     pre_last, phase_last, digit_last, commit;

    logic [4*NUM_DIGITS-1:0]  pend_val, shadow_val;
    logic [NUM_DIGITS-1:0]    pend_dp, shadow_dp;
    logic                     pend;

    logic [NUM_DIGITS-1:0]    blank;
    logic [NUM_DIGITS-1:0]    an_on;
    logic [3:0]               nib;
    logic                     dp_sel, blank_sel, lit;
    logic [6:0]               seg_on;

    assign pre_last   = (pre == '1);
    assign phase_last = (phase == '1);
    assign digit_last = (digit == DIG_W'(NUM_DIGITS - 1));
    assign commit     = pre_last && phase_last && digit_last;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h7E;  4'h1: font = 7'h30;
            4'h2: font = 7'h6D;  4'h3: font = 7'h79;
            4'h4: font = 7'h33;  4'h5: font = 7'h5B;
            4'h6: font = 7'h5F;  4'h7: font = 7'h70;
            4'h8: font = 7'h7F;  4'h9: font = 7'h7B;
            4'hA: font = 7'h77;  4'hB: font = 7'h1F;
            4'hC: font = 7'h4E;  4'hD: font = 7'h3D;
            4'hE: font = 7'h4F;  default: font = 7'h47;
        endcase
    endfunction

    // Scan counters: prescaler -> duty phase -> digit slot
    always_ff @(posedge clk) begin
        if (reset) begin
            pre   <= '0;
            phase <= '0;
            digit <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (pre_last) begin
                phase <= phase + 1'b1;
                if (phase_last)
                    digit <= digit_last ? '0 : digit + 1'b1;
            end
        end
    end

    // Load handshake: pending capture, shadow commit at frame wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            load_ack   <= 1'b0;
        end else if (commit) begin
            // A load coinciding with the wrap bypasses the pending register.
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end else if (pend) begin
                shadow_val <= pend_val;
                shadow_dp  <= pend_dp;
            end
            load_ack <= load || pend;
            pend     <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
                pend     <= 1'b1;
            end
        end
    end

`ifdef SEVENSEG_SCAN_LZB_EN
    // Blank zero digits left of the first nonzero one; last digit always shown
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            seen     = seen || (shadow_val[4*(NUM_DIGITS-1-i) +: 4] != 4'h0);
            blank[i] = !seen && (i != NUM_DIGITS - 1);
        end
    end
`else
    assign blank = '0;
`endif

    // Select active digit data and decide whether it is lit this cycle
    always_comb begin
        nib       = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit == DIG_W'(i)) begin
                nib       = shadow_val[4*(NUM_DIGITS-1-i) +: 4];
                dp_sel    = shadow_dp[NUM_DIGITS-1-i];
                blank_sel = blank[i];
            end
        end
        lit = (phase <= brightness) && !(pre == '0 && phase == '0) && !blank_sel;
        an_on = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            an_on[i] = lit && (digit == DIG_W'(i));
        seg_on = lit ? font(nib) : 7'h00;
    end

    // Registered pin drivers with polarity applied
    always_ff @(posedge clk) begin
        if (reset) begin
            an          <= {NUM_DIGITS{AN_POL}};
            seg         <= {7{SEG_POL}};
            dp_out      <= SEG_POL;
            frame_start <= 1'b0;
        end else begin
            an          <= an_on ^ {NUM_DIGITS{AN_POL}};
            seg         <= seg_on ^ {7{SEG_POL}};
            dp_out      <= (lit && dp_sel) ^ SEG_POL;
            frame_start <= (digit == '0) && (phase == '0) && (pre == '0);
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: time-based reference model plus directed load/brightness
// scenarios for sevenseg_scan (NUM_DIGITS=4, PRESCALE_BITS=2, DUTY_BITS=2).
module tb_sevenseg_scan;

    localparam int ND    = 4;
    localparam int PB    = 2;
    localparam int DB    = 2;
    localparam int PH    = 1 << PB;
    localparam int NPH   = 1 << DB;
    localparam int SLOT  = PH * NPH;
    localparam int FRAME = SLOT * ND;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dp;
    logic            load;
    logic            load_ack;
    logic [DB-1:0]   brightness;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            dp_out;
    logic            frame_start;

    sevenseg_scan #(
        .NUM_DIGITS(ND), .PRESCALE_BITS(PB), .DUTY_BITS(DB),
        .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
        .load_ack(load_ack), .brightness(brightness), .an(an), .seg(seg),
        .dp_out(dp_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: position in the scan derived from cycles since reset
    logic [6:0] FONT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    int            t;
    bit            mvalid = 0;
    logic [4*ND-1:0] m_shadow, m_pval;
    logic [ND-1:0]   m_sdp, m_pdp;
    bit            m_pend;
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;
    logic          e_dp, e_ack, e_fs;

    function automatic logic [3:0] m_nib(input int d);
        return 4'((m_shadow >> (4 * (ND - 1 - d))) & 16'hF);
    endfunction

    function automatic bit m_blank(input int d);
`ifdef SEVENSEG_SCAN_LZB_EN
        if (d == ND - 1) return 0;
        for (int k = 0; k <= d; k++)
            if (m_nib(k) != 0) return 0;
        return 1;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        int d, ph, pr;
        bit lit;
        if (reset) begin
            t = 0; m_shadow = '0; m_sdp = '0; m_pend = 0; m_pval = '0; m_pdp = '0;
            e_an = '1; e_seg = 7'h7F; e_dp = 1; e_ack = 0; e_fs = 0;
            mvalid = 1;
        end else if (mvalid) begin
            d  = (t / SLOT) % ND;
            ph = (t / PH) % NPH;
            pr = t % PH;
            lit = (ph <= int'(brightness)) && !(pr == 0 && ph == 0) && !m_blank(d);
            e_an  = lit ? ~(ND'(1) << d) : '1;
            e_seg = lit ? ~FONT[m_nib(d)] : 7'h7F;
            e_dp  = lit ? ~m_sdp[ND-1-d] : 1'b1;
            e_fs  = (t % FRAME == 0);
            if (t % FRAME == FRAME - 1) begin
                e_ack = load || m_pend;
                if (load) begin m_shadow = value; m_sdp = dp; end
                else if (m_pend) begin m_shadow = m_pval; m_sdp = m_pdp; end
                m_pend = 0;
            end else begin
                e_ack = 0;
                if (load) begin m_pend = 1; m_pval = value; m_pdp = dp; end
            end
            t++;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("an", 32'(an), 32'(e_an));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp_out", 32'(dp_out), 32'(e_dp));
            chk("load_ack", 32'(load_ack), 32'(e_ack));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
        end
    end

    task automatic wait_fs(output int waited);
        waited = 0;
        for (int k = 0; k < 4 * FRAME; k++) begin
            @(negedge clk);
            waited++;
            if (frame_start) return;
        end
        chk("fs_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_an(input logic [ND-1:0] pat, input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (an == pat) n++;
            @(negedge clk);
        end
    endtask

    task automatic count_ack(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (load_ack) n++;
        end
    endtask

    // One frame starting at the current (frame_start) cycle: seg/dp per lit digit
    task automatic sweep(output logic [7*ND-1:0] segs, output logic [ND-1:0] dps,
                         output logic [ND-1:0] seen);
        segs = '0; dps = '1; seen = '0;
        for (int k = 0; k < FRAME; k++) begin
            for (int d = 0; d < ND; d++)
                if (an == ~(ND'(1) << d)) begin
                    seen[d] = 1'b1;
                    segs[7*d +: 7] = seg;
                    dps[d] = dp_out;
                end
            @(negedge clk);
        end
    endtask

    task automatic pulse_load(input logic [4*ND-1:0] v, input logic [ND-1:0] p);
        value = v; dp = p; load = 1'b1;
        @(negedge clk);
        load = 1'b0; value = '0; dp = '0;
    endtask

    initial begin
        int n, w;
        logic [7*ND-1:0] segs;
        logic [ND-1:0] dps, seen;
        reset = 1'b1; load = 1'b0; value = '0; dp = '0; brightness = 2'd3;
        @(negedge clk);
        @(negedge clk);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        reset = 1'b0;

        // Idle, full brightness: digit 0 shows "0" after the dead cycle
        wait_fs(w);
        @(negedge clk);
        chk("idle_an_d0", 32'(an), 32'hE);
        chk("idle_seg_0", 32'(seg), 32'h01);
        wait_fs(w);
        count_an(4'b1110, SLOT, n);
        chk("lit_b3", 32'(n), 32'd15);
        wait_fs(w);
        chk("frame_period", 32'(w), 32'(FRAME - SLOT));

        brightness = 2'd0;
        wait_fs(w);
        count_an(4'b1110, SLOT, n);
        chk("lit_b0", 32'(n), 32'd3);
        count_an(4'b1101, SLOT, n);
        chk("lit_b0_d1", 32'(n), 32'd3);
        brightness = 2'd1;
        wait_fs(w);
        count_an(4'b1110, SLOT, n);
        chk("lit_b1", 32'(n), 32'd7);
        brightness = 2'd3;

        // Mid-frame load: one ack at frame end, then 1 A 2 F with dp on digit 2
        wait_fs(w);
        repeat (20) @(negedge clk);
        pulse_load(16'h1A2F, 4'b0010);
        count_ack(60, n);
        chk("ack_once", 32'(n), 32'd1);
        wait_fs(w);
        sweep(segs, dps, seen);
        chk("seg_1A2F", 32'(segs), 32'({7'h38, 7'h12, 7'h08, 7'h4F}));
        chk("dp_1A2F", 32'(dps), 32'b1011);

        // Two loads in one frame: last wins, single ack
        wait_fs(w);
        repeat (10) @(negedge clk);
        pulse_load(16'h1111, 4'b0000);
        repeat (10) @(negedge clk);
        pulse_load(16'h2222, 4'b0000);
        count_ack(60, n);
        chk("ack_two_loads", 32'(n), 32'd1);
        wait_fs(w);
        sweep(segs, dps, seen);
        chk("seg_2222", 32'(segs), 32'({4{7'h12}}));

        // Load exactly on the commit cycle
        wait_fs(w);
        repeat (FRAME - 2) @(negedge clk);
        pulse_load(16'hBEEF, 4'b0000);
        chk("ack_commit", 32'(load_ack), 32'd1);
        wait_fs(w);
        sweep(segs, dps, seen);
        chk("seg_BEEF", 32'(segs), 32'({7'h38, 7'h30, 7'h30, 7'h60}));

        // Reset with a pending load: no ack, display returns to 0000
        wait_fs(w);
        repeat (10) @(negedge clk);
        pulse_load(16'h1234, 4'b1111);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_ack(2 * FRAME + 4, n);
        chk("ack_after_reset", 32'(n), 32'd0);
        wait_fs(w);
        sweep(segs, dps, seen);
        chk("seg_0000", 32'(segs), 32'({4{7'h01}}));
`ifdef SEVENSEG_SCAN_LZB_EN
        chk("lzb_0000_seen", 32'(seen), 32'b1000);
        wait_fs(w);
        repeat (10) @(negedge clk);
        pulse_load(16'h0030, 4'b1111);
        wait_fs(w);
        wait_fs(w);
        sweep(segs, dps, seen);
        chk("lzb_0030_seen", 32'(seen), 32'b1100);
        chk("lzb_0030_seg", 32'(segs[27:14]), 32'({7'h01, 7'h06}));
`else
        chk("all_seen", 32'(seen), 32'b1111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
